shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
Multi-cycle shifter for the execute stage that performs SLL, SRL and SRA on one 32-bit operand.
- Sits directly upstream of the bit-select mux layer; the per-bit mux array remains the single-cycle path.
- This block is the area-reduced sequential alternative: it shifts an internal accumulator iteratively and reports completion through a valid/ready start handshake and a done pulse.

Parameters:
- XLEN, 32, operand/result width; must be a power of two.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start_valid  input  1  request present.
- start_ready  output  1  block can accept a request.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- operand  input  XLEN  value to shift.
- shamt  input  SHW  shift amount, 0..XLEN-1.
- busy  output  1  shift in progress.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  shifted value, held until next completion.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over all other inputs.
- Reset values:
  - state=IDLE, done=0, busy=0, result=0, accumulator=0, count=0.
  - start_ready=1 from the first cycle after reset.
- Accept: start_valid && start_ready at a rising edge (accept cycle C). Latches operand, shamt and op.
- States:
  - IDLE: start_ready=1, busy=0.
    - Accept with shamt!=0 and op!=11 -> SHIFT; accumulator<=operand, count<=shamt.
    - Accept with shamt==0 or op==11 -> stay IDLE; result<=operand, done=1 in cycle C+1.
  - SHIFT: start_ready=0, busy=1. Each edge: accumulator shifted by 1, count decremented.
    - SLL: shift left, zero fill.
    - SRL: shift right, zero fill.
    - SRA: shift right, fill with accumulator bit XLEN-1.
    - When count==1 at the edge: result<=shifted value, done<=1, -> IDLE.
- Latency: done high in cycle C+1+S for S=shamt>=1; C+1 for S=0 or op=11.
- done is high for exactly one cycle per accepted request.
- result changes only on a completion edge; otherwise stable.
- start_valid while busy: ignored, no side effect; requester must hold until accepted.
- Back-to-back: start_ready is 1 in the done cycle, so a new request may be accepted in that cycle. done then re-pulses per the new request's latency.
- Reset mid-SHIFT: operation discarded, no done pulse, all reset values apply next cycle.
- Arithmetic: shamt is unsigned SHW bits. Only low SHW bits are meaningful; no wider shift exists.

Optional Feature:
- Macro SHIFT_FAST4_EN.
- Defined:
  - In SHIFT, each edge shifts by 4 when count>=4, otherwise by 1. Count decrements by the step taken.
  - Completion occurs at the edge where count reaches 0.
  - Latency for S>=1: done at C+1+floor(S/4)+(S mod 4).
- Undefined: strictly 1 bit per cycle as above; no 4-bit shift logic is synthesised.
- Fill rules (zero / sign) are identical in both modes.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> result=0x00000000, done=0, busy=0, start_ready=1 after release.
- SLL operand=0x00000001 shamt=31 accepted at C -> busy cycles C+1..C+31, done only at C+32, result=0x80000000.
- SRA operand=0x80000000 shamt=4 -> result=0xF8000000 at C+5; SRL same inputs -> 0x08000000 at C+5.
- Zero-shift and reserved op:
  - shamt=0, operand=0xDEADBEEF -> done at C+1, result=0xDEADBEEF, busy never 1.
  - op=11 shamt=5 -> same, result=operand.
- Handshake and reset:
  - start_valid held high during SHIFT with different operand -> ignored.
  - Request accepted in the done cycle -> second result correct.
  - rst asserted at C+3 of a shamt=10 shift -> no done pulse, result=0.
- SHIFT_FAST4_EN defined: SLL 0x00000003 shamt=7 -> done at C+5, result=0x00000180. shamt=31 -> done at C+11.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Iterative SLL/SRL/SRA shifter with a valid/ready start handshake and a one-cycle done pulse.
// Define SHIFT_FAST4_EN to take 4-bit steps while at least 4 positions remain.
module shift_unit_seq #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand,
    input  logic [SHW-1:0]  shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [0:0]      state;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  count;
    logic [XLEN-1:0] shifted;
    logic [SHW-1:0]  next_count;
    logic            fill;

    assign start_ready = (state == IDLE);
    assign busy        = (state == SHIFT);

    always_comb begin
        fill       = (op_q == OP_SRA) ? acc[XLEN-1] : 1'b0;
        next_count = count - SHW'(1);
        if (op_q == OP_SLL) begin
            shifted = {acc[XLEN-2:0], 1'b0};
        end else begin
            shifted = {fill, acc[XLEN-1:1]};
        end
`ifdef SHIFT_FAST4_EN
        // A 4-bit step is only taken while it cannot overshoot the requested amount.
        if (count >= SHW'(4)) begin
            next_count = count - SHW'(4);
            if (op_q == OP_SLL) begin
                shifted = {acc[XLEN-5:0], 4'b0000};
            end else begin
                shifted = {{4{fill}}, acc[XLEN-1:4]};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            count  <= '0;
            op_q   <= OP_SLL;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        if (shamt != '0 && op != OP_RSV) begin
                            state <= SHIFT;
                            acc   <= operand;
                            count <= shamt;
                            op_q  <= op;
                        end else begin
                            result <= operand;
                            done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= shifted;
                    count <= next_count;
                    if (next_count == '0) begin
                        result <= shifted;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: transaction-level model checked every cycle plus literal expectations.
module tb_shift_unit_seq;
    localparam int XLEN = 32;
    localparam int SHW  = 5;

`ifdef SHIFT_FAST4_EN
    localparam int LAT_SLL31 = 11;
    localparam int LAT_SH4   = 2;
    localparam int LAT_SH7   = 5;
    localparam int LAT_SH8   = 3;
`else
    localparam int LAT_SLL31 = 32;
    localparam int LAT_SH4   = 5;
    localparam int LAT_SH7   = 8;
    localparam int LAT_SH8   = 9;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start_valid;
    logic            start_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] operand;
    logic [SHW-1:0]  shamt;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op(op),
        .operand(operand),
        .shamt(shamt),
        .busy(busy),
        .done(done),
        .result(result)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int lat(input logic [1:0] o, input int s);
        int l;
        if (s == 0 || o == 2'b11) l = 0;
`ifdef SHIFT_FAST4_EN
        else l = s / 4 + s % 4;
`else
        else l = s;
`endif
        return l;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input int s);
        logic [31:0] r;
        case (o)
            2'b00:   r = v << s;
            2'b01:   r = v >> s;
            2'b10:   r = 32'($signed(v) >>> s);
            default: r = v;
        endcase
        return r;
    endfunction

    // Transaction model: a request seen while the unit is expected idle completes lat() cycles later.
    bit          model_on = 1'b0;
    bit          m_pend   = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_busy   = 1'b0;
    int          m_pend_cyc;
    logic [31:0] m_pend_val;
    logic [31:0] m_result;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_on = 1'b1;
            m_pend   = 1'b0;
            m_done   = 1'b0;
            m_busy   = 1'b0;
            m_result = '0;
        end else if (model_on) begin
            if (!m_busy && start_valid) begin
                m_pend     = 1'b1;
                m_pend_cyc = cyc + lat(op, int'(shamt));
                m_pend_val = ref_shift(op, operand, int'(shamt));
            end
            m_done = m_pend && (m_pend_cyc == cyc);
            if (m_done) begin
                m_result = m_pend_val;
                m_pend   = 1'b0;
            end
            m_busy = m_pend;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("done", 32'(done), 32'(m_done));
            check("busy", 32'(busy), 32'(m_busy));
            check("start_ready", 32'(start_ready), 32'(!m_busy));
            check("result", result, m_result);
        end
    end

    task automatic wait_done(input string name, output int c, output logic [31:0] r);
        c = -1;
        r = 'x;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                c = cyc;
                r = result;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_req(input string name, input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                           output int latency, output logic [31:0] r);
        int c0;
        int cd;
        @(negedge clk);
        op = o; operand = v; shamt = s; start_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start_valid = 1'b0;
        wait_done(name, cd, r);
        latency = (cd < 0) ? -1 : cd - c0;
    endtask

    logic [1:0]  t_op [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] t_val[4] = '{32'h7000_0000, 32'hDEAD_BEEF, 32'h8765_4321, 32'h1234_5678};
    logic [4:0]  t_sh [4] = '{5'd3, 5'd16, 5'd8, 5'd4};
    logic [31:0] t_exp[4] = '{32'h0E00_0000, 32'h0000_DEAD, 32'hFF87_6543, 32'h2345_6780};

    initial begin
        int          l;
        int          c0;
        int          cd;
        int          pulses;
        logic [31:0] r;

        rst = 1'b1; start_valid = 1'b0; op = 2'b00; operand = '0; shamt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_result", result, 32'h0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        check("rst_ready", 32'(start_ready), 1);

        run_req("sll31", 2'b00, 32'h0000_0001, 5'd31, l, r);
        check("sll31_lat", 32'(l), 32'(LAT_SLL31));
        check("sll31_res", r, 32'h8000_0000);

        run_req("sra4", 2'b10, 32'h8000_0000, 5'd4, l, r);
        check("sra4_lat", 32'(l), 32'(LAT_SH4));
        check("sra4_res", r, 32'hF800_0000);
        run_req("srl4", 2'b01, 32'h8000_0000, 5'd4, l, r);
        check("srl4_lat", 32'(l), 32'(LAT_SH4));
        check("srl4_res", r, 32'h0800_0000);

        run_req("zero", 2'b00, 32'hDEAD_BEEF, 5'd0, l, r);
        check("zero_lat", 32'(l), 1);
        check("zero_res", r, 32'hDEAD_BEEF);
        run_req("rsv", 2'b11, 32'hCAFE_F00D, 5'd5, l, r);
        check("rsv_lat", 32'(l), 1);
        check("rsv_res", r, 32'hCAFE_F00D);

        run_req("sll7", 2'b00, 32'h0000_0003, 5'd7, l, r);
        check("sll7_lat", 32'(l), 32'(LAT_SH7));
        check("sll7_res", r, 32'h0000_0180);

        for (int i = 0; i < 4; i++) begin
            run_req("table", t_op[i], t_val[i], t_sh[i], l, r);
            check("table_res", r, t_exp[i]);
        end

        // start_valid held through the shift with a different request; it is taken in the done cycle.
        @(negedge clk);
        op = 2'b00; operand = 32'h0000_00F0; shamt = 5'd8; start_valid = 1'b1;
        c0 = cyc;
        @(negedge clk);
        op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd3;
        wait_done("held1", cd, r);
        check("held1_lat", 32'(cd - c0), 32'(LAT_SH8));
        check("held1_res", r, 32'h0000_F000);
        c0 = cyc;
        @(negedge clk);
        start_valid = 1'b0;
        wait_done("b2b", cd, r);
        check("b2b_lat", 32'(cd - c0), 4);
        check("b2b_res", r, 32'h1FFF_E000);

        // Reset during a 10-position shift: no completion may follow.
        @(negedge clk);
        op = 2'b00; operand = 32'h0000_0001; shamt = 5'd10; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", result, 32'h0);
        check("midrst_busy", 32'(busy), 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midrst_pulses", 32'(pulses), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
